// File: rtl/ram_arb_pkg.sv
// Shared sizes and FSM state type for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 32;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {CLEAR, RUN} state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: lone requester wins, on conflict the one not
// granted most recently wins. Grant is combinational, pointer moves on grant only.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = requester 1 (B) was granted last, so requester 0 (A) wins the next conflict
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase

    last_d = last_q;
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram32x4_arbiter.sv
// Arbitrates two requesters onto a 32x4 synchronous RAM. Defining RAM_CLEAR_EN
// adds a post-reset CLEAR phase that zeroes every word before normal operation.
module ram32x4_arbiter
  import ram_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,

  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,

  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,

  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,

  output logic              busy
);

  logic run;

`ifdef RAM_CLEAR_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  // Counter parks at the last address instead of wrapping.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      if (clr_addr_q == LAST_ADDR) begin
        state_d = RUN;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign run  = (state_q == RUN);
  assign busy = reset | (state_q == CLEAR);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  logic [1:0] arb_req, arb_gnt;

  assign arb_req = (run && !reset) ? {req_b, req_a} : 2'b00;

  rr_arbiter2 u_rr_arbiter2 (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .gnt   (arb_gnt)
  );

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

  // Reset is synchronous, but outputs are forced to their reset values while it
  // is held so a pending rvalid is dropped in the very cycle reset appears.
  always_comb begin
    gnt_a       = arb_gnt[0];
    gnt_b       = arb_gnt[1];
    ram_address = addr_q;
    ram_data    = '0;
    ram_wren    = 1'b0;

    if (reset) begin
      ram_address = '0;
`ifdef RAM_CLEAR_EN
    end else if (state_q == CLEAR) begin
      ram_address = clr_addr_q;
      ram_wren    = 1'b1;
`endif
    end else if (arb_gnt[0]) begin
      ram_address = addr_a;
      ram_data    = wdata_a;
      ram_wren    = we_a;
    end else if (arb_gnt[1]) begin
      ram_address = addr_b;
      ram_data    = wdata_b;
      ram_wren    = we_b;
    end
    addr_d = ram_address;

    rvalid_a_d = arb_gnt[0] & ~we_a;
    rvalid_b_d = arb_gnt[1] & ~we_b;

    rvalid_a = rvalid_a_q & ~reset;
    rvalid_b = rvalid_b_q & ~reset;
    rdata_a  = reset ? '0 : (rvalid_a_q ? ram_q : rdata_a_q);
    rdata_b  = reset ? '0 : (rvalid_b_q ? ram_q : rdata_b_q);

    rdata_a_d = rdata_a;
    rdata_b_d = rdata_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      addr_q     <= addr_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Bench for ram32x4_arbiter: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with reset pulses.
module tb_ram32x4_arbiter;

`ifdef RAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [4:0] addr_a = '0, addr_b = '0;
  logic [3:0] wdata_a = '0, wdata_b = '0;
  logic       gnt_a, rvalid_a, gnt_b, rvalid_b, ram_wren, busy;
  logic [3:0] rdata_a, rdata_b, ram_data;
  logic [4:0] ram_address;
  logic [3:0] ram_q = '0;
  logic [3:0] ram_mem [32];

  int n_vec = 0;
  int n_err = 0;

  ram32x4_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req_a       (req_a),
    .we_a        (we_a),
    .addr_a      (addr_a),
    .wdata_a     (wdata_a),
    .gnt_a       (gnt_a),
    .rvalid_a    (rvalid_a),
    .rdata_a     (rdata_a),
    .req_b       (req_b),
    .we_b        (we_b),
    .addr_b      (addr_b),
    .wdata_b     (wdata_b),
    .gnt_b       (gnt_b),
    .rvalid_b    (rvalid_b),
    .rdata_b     (rdata_b),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // External synchronous RAM: q is valid one cycle after its address is clocked.
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         model_on = 1'b0;
  int         m_clr_left = 0;
  logic [4:0] m_clr_addr = '0;
  bit         m_last_b = 1'b1;
  logic [3:0] m_mem [32];
  bit         m_pa = 1'b0, m_pb = 1'b0;
  logic [3:0] m_pda = '0, m_pdb = '0, m_rda = '0, m_rdb = '0;
  logic [4:0] m_hold = '0;

  always @(negedge clock) begin
    bit ga, gb, w;
    logic [4:0] a;
    logic [3:0] d, ea, eb;
    if (reset) begin
      chk("rst_gnt_a", gnt_a, 0);       chk("rst_gnt_b", gnt_b, 0);
      chk("rst_wren", ram_wren, 0);     chk("rst_addr", ram_address, 0);
      chk("rst_rvalid_a", rvalid_a, 0); chk("rst_rvalid_b", rvalid_b, 0);
      chk("rst_rdata_a", rdata_a, 0);   chk("rst_rdata_b", rdata_b, 0);
      chk("rst_busy", busy, CLR_EN);
      m_clr_left = CLR_EN ? 32 : 0;
      m_clr_addr = '0;
      m_last_b   = 1'b1;
      m_pa = 1'b0; m_pb = 1'b0; m_rda = '0; m_rdb = '0; m_hold = '0;
      model_on   = 1'b1;
    end else if (model_on) begin
      ea = m_pa ? m_pda : m_rda;
      eb = m_pb ? m_pdb : m_rdb;
      chk("rvalid_a", rvalid_a, m_pa); chk("rdata_a", rdata_a, ea);
      chk("rvalid_b", rvalid_b, m_pb); chk("rdata_b", rdata_b, eb);
      m_rda = ea; m_rdb = eb; m_pa = 1'b0; m_pb = 1'b0;
      if (m_clr_left > 0) begin
        chk("clr_busy", busy, 1);     chk("clr_gnt_a", gnt_a, 0); chk("clr_gnt_b", gnt_b, 0);
        chk("clr_wren", ram_wren, 1); chk("clr_addr", ram_address, m_clr_addr);
        chk("clr_data", ram_data, 0);
        m_mem[m_clr_addr] = 4'h0;
        m_hold = m_clr_addr;
        m_clr_left--;
        m_clr_addr++;
      end else begin
        ga = req_a && (!req_b || m_last_b);
        gb = req_b && !ga;
        chk("run_busy", busy, 0); chk("gnt_a", gnt_a, ga); chk("gnt_b", gnt_b, gb);
        if (ga || gb) begin
          w = ga ? we_a : we_b;
          a = ga ? addr_a : addr_b;
          d = ga ? wdata_a : wdata_b;
          chk("wren", ram_wren, w);
          chk("addr", ram_address, a);
          if (w) begin
            chk("wdata", ram_data, d);
            m_mem[a] = d;
          end else if (ga) begin
            m_pa = 1'b1; m_pda = m_mem[a];
          end else begin
            m_pb = 1'b1; m_pdb = m_mem[a];
          end
          m_last_b = gb;
          m_hold = a;
        end else begin
          chk("idle_wren", ram_wren, 0);
          chk("idle_addr", ram_address, m_hold);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

`ifdef RAM_CLEAR_EN
  task automatic count_busy(output int cnt, output logic [4:0] first_addr, output bit b_early);
    cnt = 0;
    first_addr = 5'h1f;
    b_early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
      if (cnt == 0) first_addr = ram_address;
      if (gnt_b) b_early = 1'b1;
      cnt++;
    end
  endtask
`endif

  initial begin
    int         cnt;
    logic [4:0] first_addr;
    bit         b_early, found, g_a, g_b;

    for (int i = 0; i < 32; i++) begin
      ram_mem[i] = 4'(i) ^ 4'h5;
      m_mem[i]   = 4'(i) ^ 4'h5;
    end

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

`ifdef RAM_CLEAR_EN
    // Clear length, and B held off until the first RUN cycle.
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd0;
    count_busy(cnt, first_addr, b_early);
    chk("clear_len", 8'(cnt), 32);
    chk("clear_first_addr", first_addr, 0);
    chk("b_during_clear", b_early, 0);
    chk("b_first_run", gnt_b, 1);
    tick();
    req_b = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Abort the clear partway and expect a full restart.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy && ram_address == 5'd16) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_addr16", found, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy(cnt, first_addr, b_early);
    chk("restart_len", 8'(cnt), 32);
    chk("restart_addr0", first_addr, 0);
`else
    @(negedge clock);
    chk("noclr_busy", busy, 0);
`endif

    // A writes 3 <= A, then B reads 3.
    tick();
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd3; wdata_a = 4'hA;
    @(negedge clock);
    chk("wr3_gnt_a", gnt_a, 1);
    tick();
    req_a = 1'b0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd3;
    @(negedge clock);
    chk("rd3_gnt_b", gnt_b, 1);
    tick();
    req_b = 1'b0;
    @(negedge clock);
    chk("rd3_rvalid_b", rvalid_b, 1);
    chk("rd3_rdata_b", rdata_b, 4'hA);

    // Both reading for four cycles: A,B,A,B.
    tick();
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd3;
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rr_gnt_a", gnt_a, (i % 2 == 0));
      chk("rr_gnt_b", gnt_b, (i % 2 == 1));
      if (i > 0) chk("rr_rvalid_a", rvalid_a, (i % 2 == 1));
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clock);
    chk("rr_last_rvalid_b", rvalid_b, 1);
    chk("rr_last_rdata_b", rdata_b, 4'hA);

    // Write 7 to address 31, reset, read it back.
    tick();
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd31; wdata_a = 4'h7;
    @(negedge clock);
    chk("wr31_gnt_a", gnt_a, 1);
    tick();
    req_a = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef RAM_CLEAR_EN
    count_busy(cnt, first_addr, b_early);
    chk("rst2_clear_len", 8'(cnt), 32);
`else
    @(negedge clock);
    chk("rst2_busy", busy, 0);
`endif
    tick();
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd31;
    @(negedge clock);
    chk("rd31_gnt_b", gnt_b, 1);
    chk("rd31_busy", busy, 0);
    tick();
    req_b = 1'b0;
    @(negedge clock);
    chk("rd31_rvalid_b", rvalid_b, 1);
    chk("rd31_rdata_b", rdata_b, CLR_EN ? 4'h0 : 4'h7);

    // Randomized traffic; each requester holds until granted.
    g_a = 1'b0;
    g_b = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick();
      reset = ($urandom_range(0, 249) == 0);
      if (reset) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end else begin
        if (!req_a || g_a) begin
          req_a   = ($urandom_range(0, 99) < 55);
          we_a    = 1'($urandom_range(0, 1));
          addr_a  = 5'($urandom_range(0, 7));
          wdata_a = 4'($urandom);
        end
        if (!req_b || g_b) begin
          req_b   = ($urandom_range(0, 99) < 55);
          we_b    = 1'($urandom_range(0, 1));
          addr_b  = 5'($urandom_range(0, 7));
          wdata_b = 4'($urandom);
        end
      end
      @(negedge clock);
      g_a = gnt_a;
      g_b = gnt_b;
    end

    tick();
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram32x4_arbiter.md
RAM32X4_ARBITER -- requirements
Module: ram32x4_arbiter

Interface
REQ-001 The block SHALL use one clock and synchronous active-high reset: clock  in  1  rising-edge clock for all state; reset  in  1  synchronous active-high reset.
REQ-002 Requester A ports SHALL be: req_a in 1 request; we_a in 1 write(1)/read(0); addr_a in 5 word address; wdata_a in 4 write data; gnt_a out 1 request accepted this cycle; rvalid_a out 1 read data valid; rdata_a out 4 read data.
REQ-003 Requester B ports SHALL mirror A with suffix _b.
REQ-004 RAM-side ports SHALL be: ram_address out 5; ram_data out 4; ram_wren out 1; ram_q in 4, which is valid one cycle after its address is clocked.
REQ-005 The block SHALL drive busy out 1, high while the memory-clear sequence runs.

Function
REQ-006 The FSM SHALL have states CLEAR and RUN.
REQ-007 In CLEAR, the block SHALL write 4'h0 to addresses 0..31 in ascending order, one per cycle (32 cycles), with ram_wren=1, busy=1, and gnt_a/gnt_b=0. It SHALL then enter RUN.
REQ-008 In RUN, the block SHALL pick at most one winner per cycle. It SHALL assert the winner's gnt combinationally in the same cycle and drive ram_address/ram_data/ram_wren from the winner's addr/wdata/we.
REQ-009 A lone requester SHALL be granted immediately.
REQ-010 When req_a and req_b are both high, the requester not granted most recently SHALL win (round-robin). The last-grant pointer SHALL update only on a grant.
REQ-011 A requester SHALL hold req/we/addr/wdata stable until it sees its gnt. Requests with no grant SHALL be neither lost nor queued internally.
REQ-012 For a granted read at cycle t, the block SHALL assert the winner's rvalid in cycle t+1 for exactly one cycle, with rdata = ram_q. A granted write SHALL produce no rvalid.
REQ-013 rdata_a/rdata_b SHALL hold their last valid value when rvalid is low.
REQ-014 With no grant, ram_wren SHALL be 0 and ram_address SHALL hold its previous value.
REQ-015 Back-to-back grants SHALL be allowed every cycle. A write at t followed by a read of the same address at t+1 SHALL return the new data.
REQ-016 Address arithmetic SHALL be 5-bit unsigned. The clear counter SHALL terminate at 31 and SHALL NOT wrap.

Reset
REQ-017 Reset SHALL set gnt_a=gnt_b=0, rvalid_a=rvalid_b=0, rdata_a=rdata_b=4'h0, ram_wren=0, ram_address=5'd0, and the last-grant pointer to B, so that A wins the first conflict.
REQ-018 Reset SHALL enter CLEAR with busy=1 when RAM_CLEAR_EN is defined, and RUN with busy=0 otherwise.
REQ-019 Reset asserted mid-operation SHALL abort any clear in progress or any pending rvalid, and SHALL restart the clear at address 0.

Configuration
REQ-020 The macro RAM_CLEAR_EN SHALL compile in the CLEAR state and its counter.
REQ-021 When RAM_CLEAR_EN is undefined, the CLEAR state and its counter SHALL be absent, busy SHALL be tied to 0, and the RAM SHALL retain its contents across reset.

Structure
REQ-022 Package ram_arb_pkg SHALL hold ADDR_W=5, DATA_W=4, DEPTH=32, and the FSM state typedef (CLEAR, RUN).
REQ-023 The round-robin choice and last-grant pointer SHALL be a sub-module rr_arbiter2 (inputs req[1:0], clock, reset; output gnt[1:0] one-hot or zero).

Verification
REQ-024 Reset with RAM_CLEAR_EN -> busy=1 for exactly 32 cycles, ram_wren=1 at addresses 0..31 with data 0; all reads afterwards return 4'h0.
REQ-025 A writes addr 5'd3 data 4'hA; next cycle B reads 5'd3 -> gnt_a at t, gnt_b at t+1, rvalid_b at t+2 with rdata_b=4'hA.
REQ-026 req_a and req_b held high for 4 cycles, both reading -> grants in order A,B,A,B; each rvalid follows its grant by one cycle.
REQ-027 req_b raised during CLEAR -> no gnt_b until the first RUN cycle; then gnt_b in that cycle.
REQ-028 Reset pulsed at clear address 17 -> clear restarts at address 0 and busy stays high for a further 32 cycles.
REQ-029 Build without RAM_CLEAR_EN; write 4'h7 to addr 5'd31, reset, then read addr 5'd31 -> busy=0 throughout, immediate grant, rdata=4'h7.
